// File: rtl/stopwatch_watch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_watch_pkg
// Shared types and constants for the watch/stopwatch control unit.
//   sw_state_t   : stopwatch run/stop/clear FSM states
//   field_t      : watch edit cursor (which time field is being edited)
//   EDIT_*       : encoding of the per-field edit command outputs
//   field_onehot : cursor -> one-hot LED pattern
// -----------------------------------------------------------------------------
package stopwatch_watch_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } sw_state_t;

    typedef enum logic [1:0] {
        FLD_MSEC = 2'd0,
        FLD_SEC  = 2'd1,
        FLD_MIN  = 2'd2,
        FLD_HOUR = 2'd3
    } field_t;

    localparam logic [1:0] EDIT_NONE = 2'b00;
    localparam logic [1:0] EDIT_UP   = 2'b01;
    localparam logic [1:0] EDIT_DOWN = 2'b11;

    function automatic logic [3:0] field_onehot(input field_t f);
        logic [3:0] oh;
        oh    = 4'b0000;
        oh[f] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/stopwatch_watch_ctrl_btn.sv
// -----------------------------------------------------------------------------
// btn_debounce_edge
// Conditions one raw push-button: 2-FF synchronizer, debounce counter, and a
// one-cycle pulse on each accepted rising edge (release produces nothing).
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   btn   : raw asynchronous button, active-high
//   level : accepted (debounced) button level
//   press : one-cycle pulse when the accepted level rises
// -----------------------------------------------------------------------------
module btn_debounce_edge #(
    parameter int DEBOUNCE_CYC = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_1_q;
    logic             sync_2_q;
    logic             level_q;
    logic             level_d_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: state is written with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (required for a shift chain).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1_q <= 1'b0;
            sync_2_q <= 1'b0;
        end else begin
            sync_1_q <= btn;
            sync_2_q <= sync_1_q;
        end
    end

    // The accepted level comes out of reset as "held": a button that is
    // already down when reset lifts must first be seen released for
    // DEBOUNCE_CYC samples, so it cannot fire a spurious press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            level_q   <= 1'b1;
            level_d_q <= 1'b1;
        end else begin
            level_d_q <= level_q;
            if (sync_2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= CNT_LAST) begin
                level_q <= sync_2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = level_q;
    assign press = level_q & ~level_d_q;

endmodule

// File: rtl/stopwatch_watch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_watch_ctrl
// Control unit for the combined watch/stopwatch: turns four push-buttons and
// the mode switches into stopwatch run/stop/clear and per-field edit commands,
// and drives four status LEDs. All outputs are registered.
// Optional feature macro: STOPWATCH_WATCH_CTRL_AUTO_REPEAT_EN (auto-repeat of
// held up/down buttons in watch edit mode).
// Ports:
//   clk             : system clock (100 MHz)
//   reset           : asynchronous, active-low reset
//   i_up/i_down     : raw edit increment/decrement buttons
//   i_right/i_left  : raw run-stop/clear buttons, or cursor move in edit mode
//   i_watch_select  : 0 = watch mode, 1 = stopwatch mode
//   i_edit          : 1 = watch edit mode enabled
//   o_run_stop      : stopwatch counting enable
//   o_clear         : stopwatch clear, one-cycle pulse
//   o_edit_msec/sec/min/hour : 00 none, 01 increment, 11 decrement (pulses)
//   o_led           : status LEDs
// -----------------------------------------------------------------------------
module stopwatch_watch_ctrl
    import stopwatch_watch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 100_000,
    parameter int REPEAT_DLY   = 50_000_000,
    parameter int REPEAT_PER   = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_right,
    input  logic       i_left,
    input  logic       i_watch_select,
    input  logic       i_edit,
    output logic       o_run_stop,
    output logic       o_clear,
    output logic [1:0] o_edit_msec,
    output logic [1:0] o_edit_sec,
    output logic [1:0] o_edit_min,
    output logic [1:0] o_edit_hour,
    output logic [3:0] o_led
);

    logic p_up, p_down, p_right, p_left;
    logic lvl_up, lvl_down, lvl_right, lvl_left;

    btn_debounce_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_up (
        .clk(clk), .reset(reset), .btn(i_up), .level(lvl_up), .press(p_up)
    );
    btn_debounce_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_down (
        .clk(clk), .reset(reset), .btn(i_down), .level(lvl_down), .press(p_down)
    );
    btn_debounce_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_right (
        .clk(clk), .reset(reset), .btn(i_right), .level(lvl_right), .press(p_right)
    );
    btn_debounce_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_left (
        .clk(clk), .reset(reset), .btn(i_left), .level(lvl_left), .press(p_left)
    );

    // Only up/down levels matter (and only for auto-repeat).
    logic unused_levels;
    assign unused_levels = ^{lvl_right, lvl_left};

    logic edit_active;
    assign edit_active = !i_watch_select && i_edit;

    logic up_cmd, down_cmd;

`ifdef STOPWATCH_WATCH_CTRL_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY_C = REP_W'(REPEAT_DLY);
    localparam logic [REP_W-1:0] REP_PER_C = REP_W'(REPEAT_PER);
    localparam logic [REP_W-1:0] REP_SAT   = REP_W'(REP_MAX);

    // Index 0 = up, 1 = down.
    logic [1:0]       rep_held, rep_press, rep_on_q, rep_first_q, rep_fire;
    logic [REP_W-1:0] rep_cnt_q [2];

    assign rep_held  = {lvl_down, lvl_up};
    assign rep_press = {p_down, p_up};

    // cnt counts cycles since the last pulse; the first gap is REPEAT_DLY,
    // later gaps REPEAT_PER.
    always_comb begin
        rep_fire = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rep_fire[i] = rep_on_q[i] && rep_held[i] &&
                          (rep_cnt_q[i] == (rep_first_q[i] ? REP_DLY_C : REP_PER_C));
        end
    end

    // NOTE: this small counter array is reset explicitly; it is flop-based
    // control state, not a RAM, so reset costs nothing and avoids X at start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_on_q    <= 2'b00;
            rep_first_q <= 2'b00;
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!edit_active || !rep_held[i]) begin
                    rep_on_q[i]    <= 1'b0;
                    rep_first_q[i] <= 1'b0;
                    rep_cnt_q[i]   <= '0;
                end else if (rep_press[i]) begin
                    rep_on_q[i]    <= 1'b1;
                    rep_first_q[i] <= 1'b1;
                    rep_cnt_q[i]   <= REP_W'(1);
                end else if (rep_on_q[i]) begin
                    if (rep_fire[i]) begin
                        rep_first_q[i] <= 1'b0;
                        rep_cnt_q[i]   <= REP_W'(1);
                    end else if (rep_cnt_q[i] != REP_SAT) begin
                        rep_cnt_q[i] <= rep_cnt_q[i] + REP_W'(1);
                    end
                end
            end
        end
    end

    assign up_cmd   = p_up   | rep_fire[0];
    assign down_cmd = p_down | rep_fire[1];
`else
    logic unused_repeat;
    assign unused_repeat = ^{lvl_up, lvl_down, REPEAT_DLY[0], REPEAT_PER[0]};

    assign up_cmd   = p_up;
    assign down_cmd = p_down;
`endif

    // ---------------- stopwatch FSM ----------------
    sw_state_t sw_q, sw_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sw_q <= ST_STOP;
        else        sw_q <= sw_d;
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sw_d = sw_q;
        unique case (sw_q)
            ST_STOP: begin
                if (i_watch_select) begin
                    if (p_right)     sw_d = ST_RUN;
                    else if (p_left) sw_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (i_watch_select && p_right) sw_d = ST_STOP;
            end
            ST_CLEAR: sw_d = ST_STOP;
            default:  sw_d = ST_STOP;
        endcase
    end

    // ---------------- edit cursor FSM ----------------
    field_t     cur_q, cur_d;
    logic [1:0] edit_cmd;
    logic [3:0] led_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_q <= FLD_MSEC;
        else        cur_q <= cur_d;
    end

    // The edit command targets the cursor position before any move in the
    // same cycle; opposing simultaneous presses cancel.
    always_comb begin
        cur_d    = cur_q;
        edit_cmd = EDIT_NONE;
        if (edit_active) begin
            if (up_cmd && !down_cmd)      edit_cmd = EDIT_UP;
            else if (down_cmd && !up_cmd) edit_cmd = EDIT_DOWN;
            if (p_left && !p_right)       cur_d = field_t'(cur_q + 2'd1);
            else if (p_right && !p_left)  cur_d = field_t'(cur_q - 2'd1);
        end
    end

    always_comb begin
        led_d = 4'b0000;
        if (i_watch_select) led_d = {1'b1, 2'b00, (sw_d == ST_RUN)};
        else if (i_edit)    led_d = field_onehot(cur_d);
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_run_stop  <= 1'b0;
            o_clear     <= 1'b0;
            o_edit_msec <= EDIT_NONE;
            o_edit_sec  <= EDIT_NONE;
            o_edit_min  <= EDIT_NONE;
            o_edit_hour <= EDIT_NONE;
            o_led       <= 4'b0000;
        end else begin
            o_run_stop  <= (sw_d == ST_RUN);
            o_clear     <= (sw_d == ST_CLEAR);
            o_edit_msec <= (cur_q == FLD_MSEC) ? edit_cmd : EDIT_NONE;
            o_edit_sec  <= (cur_q == FLD_SEC)  ? edit_cmd : EDIT_NONE;
            o_edit_min  <= (cur_q == FLD_MIN)  ? edit_cmd : EDIT_NONE;
            o_edit_hour <= (cur_q == FLD_HOUR) ? edit_cmd : EDIT_NONE;
            o_led       <= led_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_watch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_watch_ctrl
// Self-checking bench for stopwatch_watch_ctrl. A behavioural model predicts
// the registered outputs for every clock edge and queues them; a monitor pops
// and compares on the opposite clock edge. Directed scenarios are followed by
// randomized button/mode activity, then an asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_stopwatch_watch_ctrl;

    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 5;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       i_up = 1'b0, i_down = 1'b0, i_right = 1'b0, i_left = 1'b0;
    logic       i_watch_select = 1'b0, i_edit = 1'b0;
    logic       o_run_stop, o_clear;
    logic [1:0] o_edit_msec, o_edit_sec, o_edit_min, o_edit_hour;
    logic [3:0] o_led;

    stopwatch_watch_ctrl #(
        .DEBOUNCE_CYC(DEB), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut (
        .clk(clk), .reset(reset),
        .i_up(i_up), .i_down(i_down), .i_right(i_right), .i_left(i_left),
        .i_watch_select(i_watch_select), .i_edit(i_edit),
        .o_run_stop(o_run_stop), .o_clear(o_clear),
        .o_edit_msec(o_edit_msec), .o_edit_sec(o_edit_sec),
        .o_edit_min(o_edit_min), .o_edit_hour(o_edit_hour),
        .o_led(o_led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       run;
        logic       clr;
        logic [1:0] ems, es, emin, eh;
        logic [3:0] led;
    } out_t;

    out_t exp_q[$];
    bit   model_en = 1'b0;

    // Button index: 0 up, 1 down, 2 right, 3 left.
    bit s1[4], s2[4], acc[4], acc_prev[4];
    int run_len[4];
    bit m_running, m_clearing;
    int m_cursor;
    int edge_n;
    bit hold_on[2];
    int hold_start[2];

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            s1[b] = 0; s2[b] = 0; acc[b] = 1; acc_prev[b] = 1; run_len[b] = 0;
        end
        m_running = 0; m_clearing = 0; m_cursor = 0; edge_n = 0;
        for (int b = 0; b < 2; b++) begin
            hold_on[b] = 0; hold_start[b] = 0;
        end
    endtask

    task automatic model_step();
        bit   p[4];
        bit   raw[4];
        bit   cmd[2];
        bit   edit_act;
        logic [1:0] fld[4];
        out_t e;
        edge_n++;
        for (int b = 0; b < 4; b++) p[b] = acc[b] && !acc_prev[b];
        edit_act = !i_watch_select && i_edit;
        cmd[0] = p[0];
        cmd[1] = p[1];
`ifdef STOPWATCH_WATCH_CTRL_AUTO_REPEAT_EN
        for (int b = 0; b < 2; b++) begin
            int d;
            if (hold_on[b] && acc[b]) begin
                d = edge_n - hold_start[b];
                if (d >= DLY && ((d - DLY) % PER) == 0) cmd[b] = 1;
            end
            if (!edit_act || !acc[b]) hold_on[b] = 0;
            else if (p[b]) begin
                hold_on[b] = 1;
                hold_start[b] = edge_n;
            end
        end
`endif
        // stopwatch
        if (m_clearing) m_clearing = 0;
        else if (i_watch_select) begin
            if (m_running) begin
                if (p[2]) m_running = 0;
            end else if (p[2]) m_running = 1;
            else if (p[3]) m_clearing = 1;
        end
        // edit
        for (int f = 0; f < 4; f++) fld[f] = 2'b00;
        if (edit_act) begin
            if (cmd[0] != cmd[1]) fld[m_cursor] = cmd[0] ? 2'b01 : 2'b11;
            if (p[3] && !p[2])      m_cursor = (m_cursor + 1) % 4;
            else if (p[2] && !p[3]) m_cursor = (m_cursor + 3) % 4;
        end
        e.run  = m_running;
        e.clr  = m_clearing;
        e.ems  = fld[0];
        e.es   = fld[1];
        e.emin = fld[2];
        e.eh   = fld[3];
        if (i_watch_select) e.led = {1'b1, 2'b00, m_running};
        else if (i_edit)    e.led = 4'(1 << m_cursor);
        else                e.led = 4'b0000;
        exp_q.push_back(e);
        // button conditioning: synchronized samples lag the pins by two edges,
        // and the accepted level flips after DEB consecutive disagreeing samples
        raw[0] = i_up; raw[1] = i_down; raw[2] = i_right; raw[3] = i_left;
        for (int b = 0; b < 4; b++) begin
            acc_prev[b] = acc[b];
            if (s2[b] != acc[b]) begin
                run_len[b]++;
                if (run_len[b] == DEB) begin
                    acc[b] = s2[b];
                    run_len[b] = 0;
                end
            end else run_len[b] = 0;
            s2[b] = s1[b];
            s1[b] = raw[b];
        end
    endtask

    always @(posedge clk) begin
        if (model_en && reset) model_step();
    end

    // ---------------- monitor ----------------
    out_t mon_e;
    always @(negedge clk) begin
        if (model_en && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("run_stop",  32'(o_run_stop),  32'(mon_e.run));
            check("clear",     32'(o_clear),     32'(mon_e.clr));
            check("edit_msec", 32'(o_edit_msec), 32'(mon_e.ems));
            check("edit_sec",  32'(o_edit_sec),  32'(mon_e.es));
            check("edit_min",  32'(o_edit_min),  32'(mon_e.emin));
            check("edit_hour", 32'(o_edit_hour), 32'(mon_e.eh));
            check("led",       32'(o_led),       32'(mon_e.led));
        end
    end

    // ---------------- stimulus ----------------
    // mask bits: [3] up, [2] down, [1] right, [0] left
    task automatic drive(input logic [3:0] m);
        {i_up, i_down, i_right, i_left} = m;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        @(negedge clk);
        drive(m);
        repeat (hold) @(negedge clk);
        drive(4'b0000);
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_run_stop"}, 32'(o_run_stop), 32'd0);
        check({tag, "_clear"},    32'(o_clear),    32'd0);
        check({tag, "_edits"},    32'({o_edit_msec, o_edit_sec, o_edit_min, o_edit_hour}), 32'd0);
        check({tag, "_led"},      32'(o_led),      32'd0);
    endtask

    initial begin
        int pulses;
        // reset
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        model_en = 1'b1;
        repeat (DEB + 6) @(negedge clk);

        // stopwatch run / stop / clear
        i_watch_select = 1'b1;
        i_edit = 1'b0;
        press(4'b0010, 10);
        check("led_running", 32'(o_led), 32'b1001);
        press(4'b0010, 10);
        check("led_stopped", 32'(o_led), 32'b1000);
        press(4'b0010, 10);
        press(4'b0001, 10);                 // left while running: ignored
        press(4'b0010, 10);
        press(4'b0001, 10);                 // left while stopped: clear

        // watch edit cursor and edits
        i_watch_select = 1'b0;
        i_edit = 1'b1;
        repeat (3) press(4'b0001, 10);
        check("led_cursor_hour", 32'(o_led), 32'b1000);
        press(4'b0001, 10);
        check("led_cursor_msec", 32'(o_led), 32'b0001);
        press(4'b1000, 10);
        press(4'b0100, 10);
        // glitchy up: never stable for DEB samples
        @(negedge clk);
        drive(4'b1000); repeat (2) @(negedge clk);
        drive(4'b0000); @(negedge clk);
        drive(4'b1000); repeat (2) @(negedge clk);
        drive(4'b0000); repeat (DEB + 8) @(negedge clk);
        press(4'b1100, 10);                 // up+down together: no edit

        // long hold of up: auto-repeat when enabled, else one pulse
        pulses = 0;
        @(negedge clk);
        drive(4'b1000);
        repeat (40) begin
            @(negedge clk);
            if (o_edit_msec == 2'b01) pulses++;
        end
        drive(4'b0000);
        repeat (DEB + 12) begin
            @(negedge clk);
            if (o_edit_msec == 2'b01) pulses++;
        end
`ifdef STOPWATCH_WATCH_CTRL_AUTO_REPEAT_EN
        check("hold_up_pulses", 32'(pulses), 32'd5);
`else
        check("hold_up_pulses", 32'(pulses), 32'd1);
`endif

        // stopwatch keeps running while the watch is being edited
        i_watch_select = 1'b1;
        i_edit = 1'b0;
        press(4'b0010, 10);
        i_watch_select = 1'b0;
        i_edit = 1'b1;
        press(4'b0010, 10);
        press(4'b0010, 10);
        check("bg_run_hold", 32'(o_run_stop), 32'd1);
        i_watch_select = 1'b1;
        repeat (3) @(negedge clk);
        check("bg_run_back", 32'(o_run_stop), 32'd1);

        // randomized activity
        for (int it = 0; it < 200; it++) begin
            logic [3:0] m;
            int h;
            int g;
            @(negedge clk);
            i_watch_select = ($urandom_range(0, 9) < 4);
            i_edit = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) m = 4'($urandom);
            else                            m = 4'(1 << $urandom_range(0, 3));
            h = $urandom_range(1, 30);
            drive(m);
            if ($urandom_range(0, 7) == 0) begin
                repeat (h / 2) @(negedge clk);
                i_watch_select = ~i_watch_select;
                repeat (h - h / 2) @(negedge clk);
            end else begin
                repeat (h) @(negedge clk);
            end
            drive(4'b0000);
            g = $urandom_range(0, 12);
            repeat (g) @(negedge clk);
        end

        // asynchronous reset in the middle of a run
        @(negedge clk);
        i_watch_select = 1'b1;
        i_edit = 1'b0;
        repeat (DEB + 8) @(negedge clk);
        if (!m_running) press(4'b0010, 10);
        repeat (3) @(negedge clk);
        check("run_before_reset", 32'(o_run_stop), 32'd1);
        #2;
        reset = 1'b0;
        model_en = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("async_reset");
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
